// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: ALU op codes, opcode/funct constants, register
// indices and the decoded-instruction record passed from decode to issue.
package mips16_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_AND   = 4'd1,
        ALU_OR    = 4'd2,
        ALU_SLL   = 4'd3,
        ALU_SRL   = 4'd4,
        ALU_SRA   = 4'd5,
        ALU_SUB   = 4'd6,
        ALU_EQUAL = 4'd7,
        ALU_LESS  = 4'd8,
        ALU_MOVE  = 4'd9,
        ALU_EMPTY = 4'd15
    } alu_op_e;

    localparam logic [4:0] OPC_SHIFT = 5'b00110;
    localparam logic [4:0] OPC_ADDIU = 5'b01001;
    localparam logic [4:0] OPC_LI    = 5'b01101;
    localparam logic [4:0] OPC_MOVE  = 5'b01111;
    localparam logic [4:0] OPC_LW    = 5'b10011;
    localparam logic [4:0] OPC_RRR   = 5'b11100;
    localparam logic [4:0] OPC_RR    = 5'b11101;

    localparam logic [1:0] F_ADDU = 2'b01;
    localparam logic [1:0] F_SUBU = 2'b11;
    localparam logic [1:0] F_SLL  = 2'b00;
    localparam logic [1:0] F_SRL  = 2'b10;
    localparam logic [1:0] F_SRA  = 2'b11;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01101;
    localparam logic [4:0] F_CMP  = 5'b01010;
    localparam logic [4:0] F_SLT  = 5'b00010;

    localparam logic [15:0] NOP_WORD = 16'h0800;
    localparam logic [3:0]  REG_T    = 4'd8;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_REG  = 2'd1,
        SRC_IMM  = 2'd2
    } src_sel_e;

    typedef struct packed {
        alu_op_e     op;
        src_sel_e    a_sel;
        src_sel_e    b_sel;
        logic [15:0] imm;
        logic [3:0]  dest;
        logic        wb_en;
        logic        mem_read;
        logic        illegal;
    } decoded_t;

    localparam decoded_t DEC_EMPTY = '{
        op: ALU_EMPTY, a_sel: SRC_ZERO, b_sel: SRC_ZERO, imm: 16'h0000,
        dest: 4'h0, wb_en: 1'b0, mem_read: 1'b0, illegal: 1'b0
    };

    function automatic logic [15:0] operand_mux(input src_sel_e sel,
                                                input logic [15:0] rf,
                                                input logic [15:0] imm);
        case (sel)
            SRC_REG: operand_mux = rf;
            SRC_IMM: operand_mux = imm;
            default: operand_mux = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle between the decode slot / register file / execute stage and the
// issue stage. master = issue stage, slave = its surroundings.
interface alu_issue_stage_if;
    // Both handshakes transfer on a rising edge where valid & ready are high;
    // valid never depends on ready, and the producer holds its payload stable
    // while valid & !ready.
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [3:0]  rf_idx_a;
    logic [3:0]  rf_idx_b;
    logic [15:0] rf_data_a;
    logic [15:0] rf_data_b;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [3:0]  ex_dest;
    logic        ex_wb_en;
    logic        ex_mem_read;
    logic        ex_illegal;

    modport master (
        input  in_valid, instr, rf_data_a, rf_data_b, flush, ex_ready,
        output in_ready, rf_idx_a, rf_idx_b, ex_valid, ex_op, ex_a, ex_b,
               ex_dest, ex_wb_en, ex_mem_read, ex_illegal
    );

    modport slave (
        output in_valid, instr, rf_data_a, rf_data_b, flush, ex_ready,
        input  in_ready, rf_idx_a, rf_idx_b, ex_valid, ex_op, ex_a, ex_b,
               ex_dest, ex_wb_en, ex_mem_read, ex_illegal
    );
endinterface

// File: rtl/mips16_alu_decode.sv
// Combinational MIPS16 decoder: instruction word to ALU op, operand sources,
// destination and register-file read indices.
module mips16_alu_decode
    import mips16_pkg::*;
(
    input  logic [15:0] instr,
    output decoded_t    dec,
    output logic [3:0]  rf_idx_a,
    output logic [3:0]  rf_idx_b
);
    logic [3:0] fx, fy, fz;
    logic [2:0] imm3;

    assign fx   = {1'b0, instr[10:8]};
    assign fy   = {1'b0, instr[7:5]};
    assign fz   = {1'b0, instr[4:2]};
    assign imm3 = instr[4:2];

    decoded_t   d;
    logic [3:0] src_a, src_b;
    logic       legal;

    always_comb begin
        d     = DEC_EMPTY;
        src_a = 4'h0;
        src_b = 4'h0;
        legal = 1'b1;
        case (instr[15:11])
            OPC_RRR: begin
                d.a_sel = SRC_REG;  src_a = fx;
                d.b_sel = SRC_REG;  src_b = fy;
                d.dest  = fz;       d.wb_en = 1'b1;
                if (instr[1:0] == F_ADDU)      d.op = ALU_ADD;
                else if (instr[1:0] == F_SUBU) d.op = ALU_SUB;
                else                           legal = 1'b0;
            end
            OPC_ADDIU: begin
                d.op    = ALU_ADD;
                d.a_sel = SRC_REG;  src_a = fx;
                d.b_sel = SRC_IMM;  d.imm = {{8{instr[7]}}, instr[7:0]};
                d.dest  = fx;       d.wb_en = 1'b1;
            end
            OPC_RR: begin
                d.a_sel = SRC_REG;  src_a = fx;
                d.b_sel = SRC_REG;  src_b = fy;
                d.wb_en = 1'b1;
                case (instr[4:0])
                    F_AND:   begin d.op = ALU_AND;   d.dest = fx;    end
                    F_OR:    begin d.op = ALU_OR;    d.dest = fx;    end
                    F_CMP:   begin d.op = ALU_EQUAL; d.dest = REG_T; end
                    F_SLT:   begin d.op = ALU_LESS;  d.dest = REG_T; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_SHIFT: begin
                // A zero shift field encodes a shift by 8.
                d.a_sel = SRC_REG;  src_a = fy;
                d.b_sel = SRC_IMM;
                d.imm   = (imm3 == 3'd0) ? 16'd8 : {13'd0, imm3};
                d.dest  = fx;       d.wb_en = 1'b1;
                case (instr[1:0])
                    F_SLL:   d.op = ALU_SLL;
                    F_SRL:   d.op = ALU_SRL;
                    F_SRA:   d.op = ALU_SRA;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LI: begin
                d.op    = ALU_MOVE;
                d.a_sel = SRC_IMM;  d.imm = {8'h00, instr[7:0]};
                d.dest  = fx;       d.wb_en = 1'b1;
            end
            OPC_MOVE: begin
                d.op    = ALU_MOVE;
                d.a_sel = SRC_REG;  src_a = fy;
                d.dest  = fx;       d.wb_en = 1'b1;
                legal   = (instr[4:0] == 5'b00000);
            end
            OPC_LW: begin
                d.op       = ALU_ADD;
                d.a_sel    = SRC_REG;  src_a = fx;
                d.b_sel    = SRC_IMM;  d.imm = {{11{instr[4]}}, instr[4:0]};
                d.dest     = fy;       d.wb_en = 1'b1;
                d.mem_read = 1'b1;
            end
            default: legal = (instr == NOP_WORD);
        endcase

        if (!legal) begin
            d         = DEC_EMPTY;
            d.illegal = 1'b1;
        end

        dec      = d;
        rf_idx_a = (d.a_sel == SRC_REG) ? src_a : 4'h0;
        rf_idx_b = (d.b_sel == SRC_REG) ? src_b : 4'h0;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes one instruction per handshake into the EX
// register feeding the ALU, with load-use bubble and flush handling.
module alu_issue_stage
    import mips16_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.master bus,
    output logic [1:0]        bubble_count
);
    decoded_t   dec;
    logic [3:0] idx_a, idx_b;

    mips16_alu_decode u_decode (
        .instr    (bus.instr),
        .dec      (dec),
        .rf_idx_a (idx_a),
        .rf_idx_b (idx_b)
    );

    assign bus.rf_idx_a = idx_a;
    assign bus.rf_idx_b = idx_b;

    logic        ex_valid_q;
    alu_op_e     ex_op_q;
    logic [15:0] ex_a_q, ex_b_q;
    logic [3:0]  ex_dest_q;
    logic        ex_wb_en_q, ex_mem_read_q, ex_illegal_q;
    logic [1:0]  bubble_q;
    logic [3:0]  load_dest_q;

    logic hazard, in_ready, fire;

    // Only sources actually read by the instruction can collide with the load.
    assign hazard = (bubble_q != 2'd0) & bus.in_valid &
                    (((dec.a_sel == SRC_REG) & (idx_a == load_dest_q)) |
                     ((dec.b_sel == SRC_REG) & (idx_b == load_dest_q)));
    assign in_ready = (!ex_valid_q | bus.ex_ready) & !hazard;
    assign fire     = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q    <= 1'b0;
            ex_op_q       <= ALU_EMPTY;
            ex_a_q        <= 16'h0000;
            ex_b_q        <= 16'h0000;
            ex_dest_q     <= 4'h0;
            ex_wb_en_q    <= 1'b0;
            ex_mem_read_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
            bubble_q      <= 2'd0;
            load_dest_q   <= 4'h0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= ALU_EMPTY;
            bubble_q   <= 2'd0;
        end else begin
            if (fire) begin
                ex_valid_q    <= 1'b1;
                ex_op_q       <= dec.op;
                ex_a_q        <= operand_mux(dec.a_sel, bus.rf_data_a, dec.imm);
                ex_b_q        <= operand_mux(dec.b_sel, bus.rf_data_b, dec.imm);
                ex_dest_q     <= dec.dest;
                ex_wb_en_q    <= dec.wb_en;
                ex_mem_read_q <= dec.mem_read;
                ex_illegal_q  <= dec.illegal;
            end else if (bus.ex_ready) begin
                ex_valid_q <= 1'b0;
                ex_op_q    <= ALU_EMPTY;
            end

            if (fire && dec.mem_read) begin
                bubble_q    <= 2'(LOAD_BUBBLES);
                load_dest_q <= dec.dest;
            end else if (bubble_q != 2'd0) begin
                bubble_q <= bubble_q - 2'd1;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_op       = ex_op_q;
    assign bus.ex_a        = ex_a_q;
    assign bus.ex_b        = ex_b_q;
    assign bus.ex_dest     = ex_dest_q;
    assign bus.ex_wb_en    = ex_wb_en_q;
    assign bus.ex_mem_read = ex_mem_read_q;
    assign bus.ex_illegal  = ex_illegal_q;
    assign bubble_count    = bubble_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: issued instructions push their expected
// EX bundle; a negedge monitor pops and compares each one the ALU consumes.
module tb_alu_issue_stage;
    localparam int LB    = 2;
    localparam int EXP_W = 43;

    logic clk;
    logic rst;
    logic [1:0] bubble_count;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.LOAD_BUBBLES(LB)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .bubble_count (bubble_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: R0..R7 and T (8); R0 is deliberately nonzero
    logic [15:0] regs [16];
    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        regs[0] = 16'h1000; regs[1] = 16'h0005; regs[2] = 16'h0022;
        regs[3] = 16'h0007; regs[4] = 16'h0044; regs[5] = 16'h0055;
        regs[6] = 16'h0066; regs[7] = 16'h0077; regs[8] = 16'h0088;
    end
    assign bus.rf_data_a = regs[bus.rf_idx_a];
    assign bus.rf_data_b = regs[bus.rf_idx_b];

    int tests_run = 0;
    int tests_failed = 0;
    logic [EXP_W-1:0] exp_q[$];

    function automatic logic [EXP_W-1:0] pk(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] dest,
                                            input logic wb, input logic mr, input logic ill);
        return {op, a, b, dest, wb, mr, ill};
    endfunction

    logic [EXP_W-1:0] got_word;
    assign got_word = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dest,
                       bus.ex_wb_en, bus.ex_mem_read, bus.ex_illegal};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ex_valid"}, 64'(bus.ex_valid), 64'd0);
        check({tag, "_ex_op"}, 64'(bus.ex_op), 64'hF);
        check({tag, "_ex_a"}, 64'(bus.ex_a), 64'd0);
        check({tag, "_ex_b"}, 64'(bus.ex_b), 64'd0);
        check({tag, "_ex_dest"}, 64'(bus.ex_dest), 64'd0);
        check({tag, "_ex_wb_en"}, 64'(bus.ex_wb_en), 64'd0);
        check({tag, "_ex_mem_read"}, 64'(bus.ex_mem_read), 64'd0);
        check({tag, "_ex_illegal"}, 64'(bus.ex_illegal), 64'd0);
        check({tag, "_bubble_count"}, 64'(bubble_count), 64'd0);
    endtask

    // Driver: present a word, wait (bounded) for in_ready, record stalls
    task automatic issue(input logic [15:0] w, input logic [EXP_W-1:0] exp, input int exp_stalls);
        int stalls;
        stalls = 0;
        bus.in_valid = 1'b1;
        bus.instr    = w;
        #1;
        while (!bus.in_ready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!bus.in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_timeout instr=%h never accepted", w);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check($sformatf("stalls_%h", w), 64'(stalls), 64'(exp_stalls));
    endtask

    // Monitor: the ALU consumes the EX register when ex_valid & ex_ready
    always @(negedge clk) begin
        if (rst && bus.ex_valid && bus.ex_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL ex_unexpected got=%h (op,a,b,dest,wb,mr,ill)", got_word);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if (got_word !== e) begin
                    tests_failed++;
                    $display("FAIL ex_bundle got=%h expected=%h (op,a,b,dest,wb,mr,ill)", got_word, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr    = 16'h0000;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        // Decode coverage, back-to-back issue
        issue(16'hE16D, pk(4'h0, 16'h0005, 16'h0007, 4'd3, 1, 0, 0), 0);
        issue(16'h4CFE, pk(4'h0, 16'h0044, 16'hFFFE, 4'd4, 1, 0, 0), 0);
        issue(16'h6CFE, pk(4'h9, 16'h00FE, 16'h0000, 4'd4, 1, 0, 0), 0);
        issue(16'h3140, pk(4'h3, 16'h0022, 16'h0008, 4'd1, 1, 0, 0), 0);
        issue(16'h33B7, pk(4'h5, 16'h0055, 16'h0005, 4'd3, 1, 0, 0), 0);
        issue(16'h32EE, pk(4'h4, 16'h0077, 16'h0003, 4'd2, 1, 0, 0), 0);
        issue(16'hE29B, pk(4'h6, 16'h0022, 16'h0044, 4'd6, 1, 0, 0), 0);
        issue(16'hEBCC, pk(4'h1, 16'h0007, 16'h0066, 4'd3, 1, 0, 0), 0);
        issue(16'hED4D, pk(4'h2, 16'h0055, 16'h0022, 4'd5, 1, 0, 0), 0);
        issue(16'hE9EA, pk(4'h7, 16'h0005, 16'h0077, 4'd8, 1, 0, 0), 0);
        issue(16'hEF02, pk(4'h8, 16'h0077, 16'h1000, 4'd8, 1, 0, 0), 0);
        issue(16'h7E60, pk(4'h9, 16'h0007, 16'h0000, 4'd6, 1, 0, 0), 0);
        issue(16'h0800, pk(4'hF, 16'h0000, 16'h0000, 4'd0, 0, 0, 0), 0);
        issue(16'hFFFF, pk(4'hF, 16'h0000, 16'h0000, 4'd0, 0, 0, 1), 0);
        issue(16'h7E61, pk(4'hF, 16'h0000, 16'h0000, 4'd0, 0, 0, 1), 0);

        // Load-use: dependent ADDU waits LB cycles; independent ADDU does not
        issue(16'h9820, pk(4'h0, 16'h1000, 16'h0000, 4'd1, 1, 1, 0), 0);
        check("bubble_after_lw", 64'(bubble_count), 64'(LB));
        issue(16'hE16D, pk(4'h0, 16'h0005, 16'h0007, 4'd3, 1, 0, 0), LB);
        issue(16'h9820, pk(4'h0, 16'h1000, 16'h0000, 4'd1, 1, 1, 0), 0);
        issue(16'hE5DD, pk(4'h0, 16'h0055, 16'h0066, 4'd7, 1, 0, 0), 0);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back loads reload counter and latched dest (R3)
        issue(16'h9820, pk(4'h0, 16'h1000, 16'h0000, 4'd1, 1, 1, 0), 0);
        issue(16'h9A7F, pk(4'h0, 16'h0022, 16'hFFFF, 4'd3, 1, 1, 0), 0);
        check("bubble_reload", 64'(bubble_count), 64'(LB));
        issue(16'hEBCC, pk(4'h1, 16'h0007, 16'h0066, 4'd3, 1, 0, 0), LB);

        // Backpressure: EX held for 3 cycles, next instruction waits
        @(posedge clk); #1;
        bus.ex_ready = 1'b0;
        issue(16'hE5DD, pk(4'h0, 16'h0055, 16'h0066, 4'd7, 1, 0, 0), 0);
        bus.in_valid = 1'b1;
        bus.instr    = 16'hE29B;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("hold_ex_%0d", i), 64'(got_word),
                  64'(pk(4'h0, 16'h0055, 16'h0066, 4'd7, 1, 0, 0)));
            @(posedge clk); #1;
        end
        bus.ex_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.push_back(pk(4'h6, 16'h0022, 16'h0044, 4'd6, 1, 0, 0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Flush coincident with a fire: instruction dropped
        issue(16'hED4D, pk(4'h2, 16'h0055, 16'h0022, 4'd5, 1, 0, 0), 0);
        bus.in_valid = 1'b1;
        bus.instr    = 16'hE9EA;
        bus.flush    = 1'b1;
        #1;
        check("flush_fire_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_fire_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_fire_ex_op", 64'(bus.ex_op), 64'hF);
        issue(16'hE9EA, pk(4'h7, 16'h0005, 16'h0077, 4'd8, 1, 0, 0), 0);

        // Flush during a pending bubble clears the counter
        issue(16'h9820, pk(4'h0, 16'h1000, 16'h0000, 4'd1, 1, 1, 0), 0);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_bubble_count", 64'(bubble_count), 64'd0);
        check("flush_bubble_ex_valid", 64'(bus.ex_valid), 64'd0);
        check("flush_bubble_ex_op", 64'(bus.ex_op), 64'hF);
        issue(16'hE16D, pk(4'h0, 16'h0005, 16'h0007, 4'd3, 1, 0, 0), 0);

        // Asynchronous reset in the middle of a stall
        @(posedge clk); #1;
        bus.ex_ready = 1'b0;
        issue(16'h9820, pk(4'h0, 16'h1000, 16'h0000, 4'd1, 1, 1, 0), 0);
        bus.in_valid = 1'b1;
        bus.instr    = 16'hE16D;
        #1;
        check("stall_before_reset", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
